// File: rtl/aha_periph_reset_responder_pkg.sv
// ============================================================================
// Module      : aha_periph_reset_responder_pkg
// Description : State encodings and sizing helpers for the reset responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aha_periph_reset_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_GATE    = 3'd2,
        ST_ASSERT  = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/aha_sync_ff.sv
// ============================================================================
// Module      : aha_sync_ff
// Description : N-stage single-bit synchronizer, async active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aha_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync_q;

    if (STAGES > 1) begin : g_chain
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sync_q <= '0;
            else        r_sync_q <= {r_sync_q[STAGES-2:0], i_d};
        end
    end else begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_sync_q <= '0;
            else        r_sync_q <= i_d;
        end
    end

    assign o_q = r_sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/aha_periph_reset_responder.sv
// ============================================================================
// Module      : aha_periph_reset_responder
// Description : Peripheral side of the four-phase reset REQ/ACK handshake:
//               quiesce, gate clock, assert/hold reset, release, acknowledge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aha_periph_reset_responder #(
    parameter int SYNC_STAGES     = 2,
    parameter int GATE_CYCLES     = 2,
    parameter int HOLD_CYCLES     = 8,
    parameter int QUIESCE_TIMEOUT = 256
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic RESET_REQ,
    input  logic PERIPH_IDLE,
    output logic RESET_ACK,
    output logic QUIESCE_REQ,
    output logic CLK_GATE_EN,
    output logic PERIPH_RESETn,
    output logic QUIESCE_TIMED_OUT
);

    import aha_periph_reset_responder_pkg::*;

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (GATE_CYCLES < 1) begin : g_chk_gate
        $error("GATE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("HOLD_CYCLES must be >= 1");
    end
    if (QUIESCE_TIMEOUT < 1) begin : g_chk_timeout
        $error("QUIESCE_TIMEOUT must be >= 1");
    end

    localparam int c_CNT_MAX = max3(QUIESCE_TIMEOUT, GATE_CYCLES, HOLD_CYCLES);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_QT_LAST   = c_CNT_W'(QUIESCE_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_GATE_LAST = c_CNT_W'(GATE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);

    logic               w_req_s;
    state_e             r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic               r_to_q,    w_to_d;
    logic               r_ack_q,   w_ack_d;
    logic               r_qreq_q,  w_qreq_d;
    logic               r_gate_q,  w_gate_d;
    logic               r_prstn_q, w_prstn_d;

    aha_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (CLK),
        .rst_n (RESETn),
        .i_d   (RESET_REQ),
        .o_q   (w_req_s)
    );

    // QUIESCE counts up towards the timeout; ASSERT/HOLD count down to zero.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_to_d    = r_to_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_req_s) begin
                    w_state_d = ST_QUIESCE;
                    w_cnt_d   = '0;
                    w_to_d    = 1'b0;
                end
            end
            ST_QUIESCE: begin
                if (!w_req_s) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (PERIPH_IDLE) begin
                    w_state_d = ST_GATE;
                    w_cnt_d   = '0;
                end else if (r_cnt_q == c_QT_LAST) begin
                    w_state_d = ST_GATE;
                    w_cnt_d   = '0;
                    w_to_d    = 1'b1;
                end else begin
                    w_cnt_d   = r_cnt_q + c_CNT_W'(1);
                end
            end
            ST_GATE: begin
                w_state_d = ST_ASSERT;
                w_cnt_d   = c_GATE_LAST;
            end
            ST_ASSERT: begin
                if (r_cnt_q == '0) begin
                    w_state_d = ST_HOLD;
                    w_cnt_d   = c_HOLD_LAST;
                end else begin
                    w_cnt_d   = r_cnt_q - c_CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt_q == '0) begin
                    w_state_d = ST_DONE;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d   = r_cnt_q - c_CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!w_req_s) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        w_ack_d   = (w_state_d == ST_DONE);
        w_qreq_d  = (w_state_d == ST_QUIESCE) || (w_state_d == ST_GATE) ||
                    (w_state_d == ST_ASSERT)  || (w_state_d == ST_HOLD);
        w_gate_d  = (w_state_d == ST_GATE) || (w_state_d == ST_ASSERT);
        w_prstn_d = !((w_state_d == ST_ASSERT) || (w_state_d == ST_HOLD));
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= '0;
            r_to_q    <= 1'b0;
            r_ack_q   <= 1'b0;
            r_qreq_q  <= 1'b0;
            r_gate_q  <= 1'b0;
            r_prstn_q <= 1'b1;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_to_q    <= w_to_d;
            r_ack_q   <= w_ack_d;
            r_qreq_q  <= w_qreq_d;
            r_gate_q  <= w_gate_d;
            r_prstn_q <= w_prstn_d;
        end
    end

    assign RESET_ACK         = r_ack_q;
    assign QUIESCE_REQ       = r_qreq_q;
    assign CLK_GATE_EN       = r_gate_q;
    assign PERIPH_RESETn     = r_prstn_q;
    assign QUIESCE_TIMED_OUT = r_to_q;

endmodule

`default_nettype wire

// File: tb/tb_aha_periph_reset_responder.sv
// ============================================================================
// Module      : tb_aha_periph_reset_responder
// Description : Scoreboard bench for the reset responder handshake sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aha_periph_reset_responder;

    localparam int G  = 2;
    localparam int H  = 8;
    localparam int QT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic req;
    logic pidle;
    logic ack, qreq, gate, prstn, tout;

    aha_periph_reset_responder #(
        .SYNC_STAGES     (2),
        .GATE_CYCLES     (G),
        .HOLD_CYCLES     (H),
        .QUIESCE_TIMEOUT (QT)
    ) dut (
        .CLK               (clk),
        .RESETn            (rst_n),
        .RESET_REQ         (req),
        .PERIPH_IDLE       (pidle),
        .RESET_ACK         (ack),
        .QUIESCE_REQ       (qreq),
        .CLK_GATE_EN       (gate),
        .PERIPH_RESETn     (prstn),
        .QUIESCE_TIMED_OUT (tout)
    );

    always #5 clk = ~clk;

    // Output vector order: {ACK, QUIESCE_REQ, CLK_GATE_EN, PERIPH_RESETn, TIMED_OUT}
    typedef struct {
        int         cyc;
        logic [4:0] v;
        string      nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [4:0] obs;

    assign obs = {ack, qreq, gate, prstn, tout};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            n_tests++;
            if (mon_e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", mon_e.nm, mon_e.cyc, cyc);
            end else if (obs !== mon_e.v) begin
                n_fail++;
                $display("FAIL %s @cyc %0d: got %b expected %b (ack,qreq,gate,prstn,to)",
                         mon_e.nm, cyc, obs, mon_e.v);
            end
        end
    end

    function automatic logic [4:0] vec(input bit a, input bit q, input bit g, input bit r, input bit t);
        return {a, q, g, r, t};
    endfunction

    task automatic push(input int c, input logic [4:0] v, input string nm);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic push_rng(input int c0, input int c1, input logic [4:0] v, input string nm);
        for (int c = c0; c <= c1; c++) push(c, v, nm);
    endtask

    // Expected trace from request issue up to the last HOLD cycle.
    task automatic push_seq(input int k, input int gate_at, input bit to_prev, input bit to_new);
        push_rng(k + 1, k + 2, vec(0, 0, 0, 1, to_prev), "sync_delay");
        push_rng(k + 3, gate_at - 1, vec(0, 1, 0, 1, 0), "quiesce");
        push(gate_at, vec(0, 1, 1, 1, to_new), "gate");
        push_rng(gate_at + 1, gate_at + G, vec(0, 1, 1, 0, to_new), "assert");
        push_rng(gate_at + G + 1, gate_at + G + H, vec(0, 1, 0, 0, to_new), "hold");
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d checks never reached, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic nominal(input bit to_prev);
        int k;
        k = cyc;
        pidle = 1'b1;
        push_seq(k, k + 4, to_prev, 1'b0);
        push_rng(k + 15, k + 21, vec(1, 0, 0, 1, 0), "done_ack");
        push_rng(k + 22, k + 24, vec(0, 0, 0, 1, 0), "ack_release");
        req = 1'b1;
        wait_until(k + 19);
        req = 1'b0;
        drain();
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        req   = 1'b0;
        pidle = 1'b0;
        push_rng(1, 3, vec(0, 0, 0, 1, 0), "reset_state");
        wait_until(3);
        rst_n = 1'b1;
        drain();

        // Nominal sequence
        nominal(1'b0);

        // Quiesce timeout, flag held through DONE and IDLE
        k = cyc;
        pidle = 1'b0;
        push_seq(k, k + 7, 1'b0, 1'b1);
        push_rng(k + 18, k + 22, vec(1, 0, 0, 1, 1), "timeout_done");
        push_rng(k + 23, k + 25, vec(0, 0, 0, 1, 1), "timeout_idle");
        req = 1'b1;
        wait_until(k + 20);
        req = 1'b0;
        drain();

        // Back-to-back request clears the sticky flag
        nominal(1'b1);

        // Abort in QUIESCE; drop lands on the same cycle the timeout would fire
        k = cyc;
        pidle = 1'b0;
        push_rng(k + 1, k + 2, vec(0, 0, 0, 1, 0), "abort_sync");
        push_rng(k + 3, k + 6, vec(0, 1, 0, 1, 0), "abort_quiesce");
        push_rng(k + 7, k + 12, vec(0, 0, 0, 1, 0), "abort_idle");
        req = 1'b1;
        wait_until(k + 4);
        req = 1'b0;
        drain();

        // Early REQ drop during HOLD: single-cycle ACK
        k = cyc;
        pidle = 1'b1;
        push_seq(k, k + 4, 1'b0, 1'b0);
        push(k + 15, vec(1, 0, 0, 1, 0), "early_drop_ack");
        push_rng(k + 16, k + 18, vec(0, 0, 0, 1, 0), "early_drop_idle");
        req = 1'b1;
        wait_until(k + 8);
        req = 1'b0;
        drain();

        // RESETn mid-ASSERT: outputs return to reset values without a clock edge
        k = cyc;
        pidle = 1'b1;
        push_rng(k + 1, k + 2, vec(0, 0, 0, 1, 0), "rst_sync");
        push(k + 3, vec(0, 1, 0, 1, 0), "rst_quiesce");
        push(k + 4, vec(0, 1, 1, 1, 0), "rst_gate");
        push(k + 5, vec(0, 1, 1, 0, 0), "rst_assert");
        push_rng(k + 6, k + 12, vec(0, 0, 0, 1, 0), "rst_abort");
        req = 1'b1;
        wait_until(k + 5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // PERIPH_IDLE rises in the same cycle the timeout expires
        k = cyc;
        pidle = 1'b0;
        push_seq(k, k + 7, 1'b0, 1'b0);
        push_rng(k + 18, k + 21, vec(1, 0, 0, 1, 0), "tie_done");
        push_rng(k + 22, k + 24, vec(0, 0, 0, 1, 0), "tie_idle");
        req = 1'b1;
        wait_until(k + 6);
        pidle = 1'b1;
        wait_until(k + 19);
        req = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
